hex_display_ctrl: RTL

HEX_DISPLAY_CTRL -- requirements
Module: hex_display_ctrl

---
 rtl/hex_display_ctrl_pkg.sv | 35 +++
 rtl/hex_display_ctrl_lut.sv | 34 +++
 rtl/hex_display_ctrl.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/hex_display_ctrl_pkg.sv
// Shared definitions for the hex display controller.
// Holds the active-low 7-segment glyphs (bit 0 = segment a .. bit 6 = segment g),
// the blank pattern and the default parameter values.
package hex_display_ctrl_pkg;

    // One digit's worth of active-low segment drive.
    typedef logic [6:0] seg_t;

    // Default number of digits driven by the controller.
    localparam int DIGITS_DEFAULT    = 6;
    // Default clock cycles per blink half-period.
    localparam int BLINK_DIV_DEFAULT = 25000000;

    // Hex glyphs, active-low.
    localparam seg_t SEG_0 = 7'h40;
    localparam seg_t SEG_1 = 7'h79;
    localparam seg_t SEG_2 = 7'h24;
    localparam seg_t SEG_3 = 7'h30;
    localparam seg_t SEG_4 = 7'h19;
    localparam seg_t SEG_5 = 7'h12;
    localparam seg_t SEG_6 = 7'h02;
    localparam seg_t SEG_7 = 7'h78;
    localparam seg_t SEG_8 = 7'h00;
    localparam seg_t SEG_9 = 7'h10;
    localparam seg_t SEG_A = 7'h08;
    localparam seg_t SEG_B = 7'h03;
    localparam seg_t SEG_C = 7'h46;
    localparam seg_t SEG_D = 7'h21;
    localparam seg_t SEG_E = 7'h06;
    localparam seg_t SEG_F = 7'h0E;

    // All segments off.
    localparam seg_t SEG_BLANK = 7'h7F;

endpackage : hex_display_ctrl_pkg

// File: rtl/hex_display_ctrl_lut.sv
// Combinational nibble-to-glyph decoder for one 7-segment digit.
// Output is active-low; an out-of-range nibble (X in simulation) maps to blank.
module hex_seg_lut
    import hex_display_ctrl_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    // Map the nibble onto its hex glyph.
    always_comb begin
        seg_o = SEG_BLANK;
        case (nibble_i)
            4'h0:    seg_o = SEG_0;
            4'h1:    seg_o = SEG_1;
            4'h2:    seg_o = SEG_2;
            4'h3:    seg_o = SEG_3;
            4'h4:    seg_o = SEG_4;
            4'h5:    seg_o = SEG_5;
            4'h6:    seg_o = SEG_6;
            4'h7:    seg_o = SEG_7;
            4'h8:    seg_o = SEG_8;
            4'h9:    seg_o = SEG_9;
            4'hA:    seg_o = SEG_A;
            4'hB:    seg_o = SEG_B;
            4'hC:    seg_o = SEG_C;
            4'hD:    seg_o = SEG_D;
            4'hE:    seg_o = SEG_E;
            4'hF:    seg_o = SEG_F;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule : hex_seg_lut

// File: rtl/hex_display_ctrl.sv
// Multi-digit hex 7-segment display controller.
// A number is captured on a valid/ready handshake and shown one edge later on a
// registered, active-low segment bus. Leading-zero suppression and per-digit
// blinking both force digits blank; the two sources are ORed. Display controls
// are registered alongside the value so they line up with it on hex_seg.
module hex_display_ctrl
    import hex_display_ctrl_pkg::*;
#(
    parameter int DIGITS    = DIGITS_DEFAULT,
    parameter int BLINK_DIV = BLINK_DIV_DEFAULT
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [4*DIGITS-1:0]   value,
    input  logic                  lz_blank,
    input  logic                  blink_en,
    input  logic [DIGITS-1:0]     blink_mask,
    output logic [7*DIGITS-1:0]   hex_seg
);

    // Counter wide enough to hold BLINK_DIV-1 (BLINK_DIV >= 2 keeps this >= 1).
    localparam int CNT_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Handshake and captured value.
    logic                  load_s;
    logic                  ready_q;
    logic                  ready_d;
    logic [4*DIGITS-1:0]   value_q;
    logic [4*DIGITS-1:0]   value_d;

    // Display controls, registered so they share the value's latency.
    logic                  lz_q;
    logic                  blink_en_q;
    logic [DIGITS-1:0]     mask_q;

    // Blink timebase.
    logic [CNT_W-1:0]      cnt_q;
    logic [CNT_W-1:0]      cnt_d;
    logic                  phase_q;
    logic                  phase_d;

    // Decode and blanking.
    logic [7*DIGITS-1:0]   glyph_s;
    logic [DIGITS-1:0]     lz_kill_s;
    logic [DIGITS-1:0]     blink_kill_s;
    logic [7*DIGITS-1:0]   seg_d;
    logic [7*DIGITS-1:0]   seg_q;

    assign load_s     = load_valid & ready_q;
    assign load_ready = ready_q;
    assign hex_seg    = seg_q;

    // One decoder per digit, fed from the captured value.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        hex_seg_lut u_lut (
            .nibble_i (value_q[4*gi +: 4]),
            .seg_o    (glyph_s[7*gi +: 7])
        );
    end

    // Capture on handshake; ready drops for exactly the cycle after a load.
    always_comb begin
        value_d = value_q;
        ready_d = 1'b1;
        if (load_s) begin
            value_d = value;
            ready_d = 1'b0;
        end else begin
            value_d = value_q;
            ready_d = 1'b1;
        end
    end

    // Blink counter runs 0..BLINK_DIV-1 and flips the phase on each wrap; held at 0 when disabled.
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (blink_en) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d   = '0;
                phase_d = ~phase_q;
            end else begin
                cnt_d   = cnt_q + CNT_ONE;
                phase_d = phase_q;
            end
        end else begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end
    end

    // Leading-zero suppression: scan from the top digit down, blank until the first non-zero nibble.
    always_comb begin
        logic seen_nonzero;
        seen_nonzero = 1'b0;
        lz_kill_s    = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (value_q[4*i +: 4] != 4'h0) begin
                seen_nonzero = 1'b1;
            end else begin
                seen_nonzero = seen_nonzero;
            end
            // Digit 0 always shows something, even for an all-zero value.
            lz_kill_s[i] = lz_q && !seen_nonzero && (i != 0);
        end
    end

    // Blink blanking: masked digits go dark during phase 1.
    always_comb begin
        blink_kill_s = '0;
        if (blink_en_q && phase_q) begin
            blink_kill_s = mask_q;
        end else begin
            blink_kill_s = '0;
        end
    end

    // Merge glyphs with the ORed blank sources.
    always_comb begin
        seg_d = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (lz_kill_s[i] || blink_kill_s[i]) begin
                seg_d[7*i +: 7] = SEG_BLANK;
            end else begin
                seg_d[7*i +: 7] = glyph_s[7*i +: 7];
            end
        end
    end

    // Handshake, value and control sampling registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ready_q    <= 1'b0;
            value_q    <= '0;
            lz_q       <= 1'b0;
            blink_en_q <= 1'b0;
            mask_q     <= '0;
        end else begin
            ready_q    <= ready_d;
            value_q    <= value_d;
            lz_q       <= lz_blank;
            blink_en_q <= blink_en;
            mask_q     <= blink_mask;
        end
    end

    // Blink timebase registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    // Registered segment output; every digit blank while in reset.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            seg_q <= '1;
        end else begin
            seg_q <= seg_d;
        end
    end

endmodule : hex_display_ctrl
